// File: rtl/alu_pkg.sv
// alu_pkg: shared multiplier defaults, sign-mode encodings and a clog2 helper
package alu_pkg;
  localparam int ALU_MUL_WIDTH = 32;
  typedef enum logic [1:0] {MUL_OP_MUL, MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU} mul_op_e;
  function automatic logic [1:0] mul_signs(input mul_op_e op);
    return op == MUL_OP_MULH ? 2'b11 : op == MUL_OP_MULHSU ? 2'b10 : 2'b00;
  endfunction
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/alu_mul_tree_level.sv
// alu_mul_tree_level: one registered adder-tree level, N operands -> N/2 pairwise sums
// Ports: clk, rst_n (async active-low), i_stall (hold), i_flush (clear valid),
//   i_valid/i_side/i_data in, o_valid/o_side/o_data registered out.
module alu_mul_tree_level #(
  parameter int N  = 32,
  parameter int DW = 64,
  parameter int SW = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_stall,
  input  logic                     i_flush,
  input  logic                     i_valid,
  input  logic [SW-1:0]            i_side,
  input  logic [N-1:0][DW-1:0]     i_data,
  output logic                     o_valid,
  output logic [SW-1:0]            o_side,
  output logic [N/2-1:0][DW-1:0]   o_data
);
  logic [N/2-1:0][DW-1:0] w_sum;
  logic [N/2-1:0][DW-1:0] r_data;
  logic [SW-1:0]          r_side;
  logic                   r_valid;
  for (genvar k = 0; k < N/2; k++) begin : g_add
    assign w_sum[k] = i_data[2*k] + i_data[2*k+1];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_side  <= '0;
      r_data  <= '0;
    end else begin
      if (i_flush) r_valid <= 1'b0;
      else if (!i_stall) r_valid <= i_valid;
      if (!i_stall) begin
        r_side <= i_side;
        r_data <= w_sum;
      end
    end
  end
  assign o_valid = r_valid;
  assign o_side  = r_side;
  assign o_data  = r_data;
endmodule

// File: rtl/alu_mul_pipe.sv
// alu_mul_pipe: fully pipelined WIDTH x WIDTH -> 2*WIDTH signed/unsigned/mixed multiplier
// Ports: clk, rst (async, active-low), in_valid/in_ready/src_A/src_B/sign_A/sign_B/in_tag issue side,
//   flush, out_valid/out_ready/dest/out_tag result side, busy.
// Latency is clog2(WIDTH)+3 stages: magnitude, partial products, clog2(WIDTH) tree levels, sign fix.
// Option: define ALU_MUL_FLUSH_EN to make flush kill every in-flight op; otherwise flush is ignored.
module alu_mul_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_MUL_WIDTH,
  parameter int TAG_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   src_A,
  input  logic [WIDTH-1:0]   src_B,
  input  logic               sign_A,
  input  logic               sign_B,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] dest,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);
  localparam int LOG = clog2(WIDTH);
  localparam int DW  = 2 * WIDTH;
  localparam int SW  = TAG_W + 1;
  logic                      w_stall;
  logic                      w_flush;
  logic [WIDTH-1:0]          w_mag_a;
  logic [WIDTH-1:0]          w_mag_b;
  logic [WIDTH-1:0][DW-1:0]  w_pp;
  logic [LOG-1:0]            w_lvl_v;
  logic                      w_tree_v;
  logic [SW-1:0]             w_tree_side;
  logic [DW-1:0]             w_tree_sum;
  logic                      r_s0_valid;
  logic [WIDTH-1:0]          r_s0_a;
  logic [WIDTH-1:0]          r_s0_b;
  logic [SW-1:0]             r_s0_side;
  logic                      r_s1_valid;
  logic [WIDTH-1:0][DW-1:0]  r_s1_pp;
  logic [SW-1:0]             r_s1_side;
  logic                      r_out_valid;
  logic [DW-1:0]             r_dest;
  logic [TAG_W-1:0]          r_out_tag;
`ifdef ALU_MUL_FLUSH_EN
  assign w_flush = flush;
`else
  logic w_unused_flush;
  assign w_unused_flush = flush;
  assign w_flush = 1'b0;
`endif
  assign w_stall  = r_out_valid & ~out_ready;
  assign in_ready = ~w_stall;
  // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude
  assign w_mag_a = (sign_A & src_A[WIDTH-1]) ? -src_A : src_A;
  assign w_mag_b = (sign_B & src_B[WIDTH-1]) ? -src_B : src_B;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s0_valid <= 1'b0;
      r_s0_a     <= '0;
      r_s0_b     <= '0;
      r_s0_side  <= '0;
      r_s1_valid <= 1'b0;
      r_s1_pp    <= '0;
      r_s1_side  <= '0;
    end else begin
      if (w_flush) begin
        r_s0_valid <= 1'b0;
        r_s1_valid <= 1'b0;
      end else if (!w_stall) begin
        r_s0_valid <= in_valid;
        r_s1_valid <= r_s0_valid;
      end
      if (!w_stall) begin
        r_s0_a    <= w_mag_a;
        r_s0_b    <= w_mag_b;
        r_s0_side <= {(sign_A & src_A[WIDTH-1]) ^ (sign_B & src_B[WIDTH-1]), in_tag};
        r_s1_pp   <= w_pp;
        r_s1_side <= r_s0_side;
      end
    end
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_pp
    assign w_pp[i] = r_s0_b[i] ? (DW'(r_s0_a) << i) : '0;
  end
  for (genvar l = 0; l < LOG; l++) begin : g_lvl
    localparam int N = WIDTH >> l;
    logic [N-1:0][DW-1:0]   w_in;
    logic                   w_in_v;
    logic [SW-1:0]          w_in_side;
    logic [N/2-1:0][DW-1:0] w_sum;
    logic                   w_v;
    logic [SW-1:0]          w_side;
    if (l == 0) begin : g_src
      assign w_in      = r_s1_pp;
      assign w_in_v    = r_s1_valid;
      assign w_in_side = r_s1_side;
    end else begin : g_src
      assign w_in      = g_lvl[l-1].w_sum;
      assign w_in_v    = g_lvl[l-1].w_v;
      assign w_in_side = g_lvl[l-1].w_side;
    end
    alu_mul_tree_level #(.N(N), .DW(DW), .SW(SW)) u_lvl (
      .clk     (clk),
      .rst_n   (rst),
      .i_stall (w_stall),
      .i_flush (w_flush),
      .i_valid (w_in_v),
      .i_side  (w_in_side),
      .i_data  (w_in),
      .o_valid (w_v),
      .o_side  (w_side),
      .o_data  (w_sum)
    );
    assign w_lvl_v[l] = w_v;
  end
  assign w_tree_v    = g_lvl[LOG-1].w_v;
  assign w_tree_side = g_lvl[LOG-1].w_side;
  assign w_tree_sum  = g_lvl[LOG-1].w_sum[0];
  // dest/out_tag only load on a real op so they hold the last result across bubbles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_dest      <= '0;
      r_out_tag   <= '0;
    end else begin
      if (w_flush) r_out_valid <= 1'b0;
      else if (!w_stall) r_out_valid <= w_tree_v;
      if (!w_stall && w_tree_v) begin
        r_dest    <= w_tree_side[TAG_W] ? -w_tree_sum : w_tree_sum;
        r_out_tag <= w_tree_side[TAG_W-1:0];
      end
    end
  end
  assign out_valid = r_out_valid;
  assign dest      = r_dest;
  assign out_tag   = r_out_tag;
  assign busy      = r_s0_valid | r_s1_valid | (|w_lvl_v) | r_out_valid;
endmodule

// File: tb/tb_alu_mul_pipe.sv
// tb_alu_mul_pipe: directed and streamed checks of alu_mul_pipe against a sign-extend-and-multiply model
module tb_alu_mul_pipe;
  import alu_pkg::*;
  localparam int W  = 32;
  localparam int TW = 5;
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  src_A = '0;
  logic [W-1:0]  src_B = '0;
  logic          sign_A = 1'b0;
  logic          sign_B = 1'b0;
  logic [TW-1:0] in_tag = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [2*W-1:0] dest;
  logic [TW-1:0] out_tag;
  logic          busy;
  int n_chk = 0, n_fail = 0, run = 0, max_run = 0, n_acc = 0, n_hs = 0;
  logic [63:0]   qd[$];
  logic [TW-1:0] qt[$];

  alu_mul_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .src_A(src_A), .src_B(src_B), .sign_A(sign_A), .sign_B(sign_B), .in_tag(in_tag),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .dest(dest),
    .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sa, input logic sb);
    logic [63:0] ea, eb;
    ea = sa ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sb ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s, input logic [TW-1:0] t);
    src_A = a; src_B = b; sign_A = s[1]; sign_B = s[0]; in_tag = t; in_valid = 1'b1;
  endtask

  // single op: valid must appear exactly 8 edges after presentation, not 7
  task automatic single_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] s, input logic [TW-1:0] t, input logic [63:0] exp);
    @(posedge clk); #1;
    drive(a, b, s, t);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check({name, "_early"}, out_valid, 1'b0);
    @(negedge clk);
    check({name, "_valid"}, out_valid, 1'b1);
    check(name, dest, exp);
    check({name, "_tag"}, out_tag, t);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("in_ready", in_ready, !(out_valid && !out_ready));
      run = out_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (out_valid && out_ready) begin
        n_hs++;
        check("q_nonempty", qd.size() != 0, 1'b1);
        if (qd.size() != 0) begin
          check("res_dest", dest, qd.pop_front());
          check("res_tag", out_tag, qt.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        n_acc++;
        qd.push_back(model(src_A, src_B, sign_A, sign_B));
        qt.push_back(in_tag);
      end
    end
  end

  initial begin
    int cnt, acc0, hs0, sent, guard;
    logic acc;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_dest", dest, 64'h0);
    check("rst_tag", out_tag, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    check("rst_in_ready", in_ready, 1'b1);

    single_op("umul_max", 32'hFFFFFFFF, 32'hFFFFFFFF, mul_signs(MUL_OP_MULHU), 5'd1, 64'hFFFFFFFE00000001);
    single_op("smul_neg3x7", 32'hFFFFFFFD, 32'd7, mul_signs(MUL_OP_MULH), 5'd2, 64'hFFFFFFFFFFFFFFEB);
    single_op("smul_minsq", 32'h80000000, 32'h80000000, mul_signs(MUL_OP_MULH), 5'd3, 64'h4000000000000000);
    single_op("mixed_m1", 32'hFFFFFFFF, 32'hFFFFFFFF, mul_signs(MUL_OP_MULHSU), 5'd4, 64'hFFFFFFFF00000001);
    single_op("smul_minx1", 32'h80000000, 32'd1, 2'b11, 5'd5, 64'hFFFFFFFF80000000);
    single_op("umul_zero", 32'h0, 32'h12345678, 2'b00, 5'd6, 64'h0);
    repeat (2) @(negedge clk);
    check("hold_dest", dest, 64'h0);

    // back-to-back
    max_run = 0;
    acc0 = n_acc; hs0 = n_hs;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      drive($urandom, $urandom, 2'($urandom_range(0, 3)), TW'(i));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 40 && busy; k++) @(posedge clk);
    @(negedge clk);
    check("b2b_run", max_run, 20);
    check("b2b_count", n_hs - hs0, 20);
    check("b2b_acc", n_acc - acc0, 20);

    // backpressure
    acc0 = n_acc; hs0 = n_hs; sent = 0; guard = 0;
    @(posedge clk); #1;
    drive($urandom, $urandom, 2'($urandom_range(0, 3)), TW'(sent));
    while (sent < 30 && guard < 600) begin
      guard++;
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = $urandom_range(0, 1) != 0;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        drive($urandom, $urandom, 2'($urandom_range(0, 3)), TW'(sent));
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_sent", sent, 30);
    for (int k = 0; k < 60 && busy; k++) @(posedge clk);
    @(negedge clk);
    check("bp_drained", busy, 1'b0);
    check("bp_acc", n_acc - acc0, 30);
    check("bp_hs", n_hs - hs0, 30);
    check("bp_queue", qd.size(), 0);

    // reset with ops in flight
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      drive($urandom, $urandom, 2'b11, TW'(i + 10));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_dest", dest, 64'h0);
    qd.delete(); qt.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("rst_no_out", cnt, 0);

`ifdef ALU_MUL_FLUSH_EN
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      drive($urandom, $urandom, 2'b00, TW'(i + 20));
      @(posedge clk); #1;
    end
    drive(32'd3, 32'd3, 2'b00, 5'd31);
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    qd.delete(); qt.delete();
    check("flush_valid", out_valid, 1'b0);
    check("flush_busy", busy, 1'b0);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("flush_no_out", cnt, 0);
`endif

    single_op("post_rst", 32'd6, 32'hFFFFFFF9, 2'b01, 5'd9, 64'hFFFFFFFFFFFFFFD6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
